// File: rtl/frame_color_classifier_if.sv
// Pixel/sync bus between the frame-buffer read side and frame_color_classifier.
//   PIXEL_IN      : RGB332 pixel {R[7:5],G[4:2],B[1:0]}, MEM_LATENCY cycles behind X/Y
//   VGA_PIXEL_X/Y : current VGA column / row
//   VGA_VSYNC_NEG : vertical sync, active low
//   RESULT        : {valid, count[5:0], class[1:0]} colour report
// master = pixel/sync source, slave = classifier.
interface frame_color_classifier_if;
  logic [7:0] PIXEL_IN;
  logic [9:0] VGA_PIXEL_X;
  logic [9:0] VGA_PIXEL_Y;
  logic       VGA_VSYNC_NEG;
  logic [8:0] RESULT;

  modport master (
    output PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    input  RESULT
  );

  modport slave (
    input  PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    output RESULT
  );
endinterface

// File: rtl/frame_color_classifier.sv
// frame_color_classifier
// Classifies each RGB332 pixel inside the SCREEN_W x SCREEN_H window as red,
// blue or neither, counts red/blue per frame, and on every VSYNC falling edge
// publishes the dominant colour and a scaled count on RESULT.
// Ports:
//   CLK   : VGA pixel clock
//   RESET : synchronous, active-high
//   bus   : frame_color_classifier_if.slave (PIXEL_IN, VGA_PIXEL_X/Y,
//           VGA_VSYNC_NEG in; RESULT out = {valid, count[5:0], class[1:0]})
module frame_color_classifier #(
  parameter int unsigned SCREEN_W    = 176,
  parameter int unsigned SCREEN_H    = 144,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned R_HI        = 5,
  parameter int unsigned GB_LO       = 1,
  parameter int unsigned B_HI        = 2,
  parameter int unsigned RG_LO       = 2,
  parameter int unsigned MIN_COUNT   = 2000,
  parameter int unsigned COUNT_SHIFT = 9
) (
  input logic                     CLK,
  input logic                     RESET,
  frame_color_classifier_if.slave bus
);

  typedef enum logic [1:0] {WAIT_SYNC, ACCUM, DECIDE} state_t;

  localparam logic [14:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [14:0]            red_cnt_q, red_cnt_d;
  logic [14:0]            blue_cnt_q, blue_cnt_d;
  logic [14:0]            snap_r_q, snap_r_d;
  logic [14:0]            snap_b_q, snap_b_d;
  logic [8:0]             result_q, result_d;
  logic                   vs_d_q, vs_d_d;
  logic [MEM_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

  logic [2:0]  pix_r, pix_g;
  logic [1:0]  pix_b;
  logic        in_win, pix_vld, is_red, is_blue, cnt_red, cnt_blue, fall;
  logic        red_win, blue_win;
  logic [14:0] win_cnt, win_shift;
  logic [5:0]  win_cnt6;

  assign pix_r = bus.PIXEL_IN[7:5];
  assign pix_g = bus.PIXEL_IN[4:2];
  assign pix_b = bus.PIXEL_IN[1:0];

  assign in_win = (bus.VGA_PIXEL_X < 10'(SCREEN_W)) && (bus.VGA_PIXEL_Y < 10'(SCREEN_H));

  // The window flag travels alongside the memory read so it lines up with
  // the pixel that the coordinate addressed.
  assign pix_vld = vld_pipe_q[MEM_LATENCY-1];

  assign is_red  = (pix_r >= 3'(R_HI)) && (pix_g <= 3'(GB_LO)) && (pix_b <= 2'(GB_LO));
  assign is_blue = (pix_b >= 2'(B_HI)) && (pix_r <= 3'(RG_LO)) && (pix_g <= 3'(RG_LO));

  // Red takes priority should a parameter set ever make both tests true.
  assign cnt_red  = pix_vld & is_red;
  assign cnt_blue = pix_vld & is_blue & ~is_red;

  assign fall = vs_d_q & ~bus.VGA_VSYNC_NEG;

  // Decision on the snapshot of the frame that just ended; ties are never a win.
  assign red_win   = (snap_r_q >= 15'(MIN_COUNT)) && (snap_r_q > snap_b_q);
  assign blue_win  = (snap_b_q >= 15'(MIN_COUNT)) && (snap_b_q > snap_r_q);
  assign win_cnt   = red_win ? snap_r_q : snap_b_q;
  assign win_shift = win_cnt >> COUNT_SHIFT;
  assign win_cnt6  = (win_shift > 15'd63) ? 6'd63 : win_shift[5:0];

  assign bus.RESULT = result_q;

  always_comb begin
    vld_pipe_d[0] = in_win;
    for (int i = 1; i < int'(MEM_LATENCY); i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    red_cnt_d  = red_cnt_q;
    blue_cnt_d = blue_cnt_q;
    snap_r_d   = snap_r_q;
    snap_b_d   = snap_b_q;
    result_d   = result_q;
    vs_d_d     = bus.VGA_VSYNC_NEG;

    case (state_q)
      WAIT_SYNC: begin
        if (fall) begin
          red_cnt_d  = '0;
          blue_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        // A pixel landing on the fall cycle belongs to neither frame.
        if (fall) begin
          snap_r_d   = red_cnt_q;
          snap_b_d   = blue_cnt_q;
          red_cnt_d  = '0;
          blue_cnt_d = '0;
          state_d    = DECIDE;
        end else begin
          if (cnt_red && red_cnt_q != CNT_MAX)   red_cnt_d  = red_cnt_q + 15'd1;
          if (cnt_blue && blue_cnt_q != CNT_MAX) blue_cnt_d = blue_cnt_q + 15'd1;
        end
      end
      DECIDE: begin
        // Counting for the new frame already runs here; a second fall is ignored.
        if (cnt_red && red_cnt_q != CNT_MAX)   red_cnt_d  = red_cnt_q + 15'd1;
        if (cnt_blue && blue_cnt_q != CNT_MAX) blue_cnt_d = blue_cnt_q + 15'd1;
        if (red_win)       result_d = {1'b1, win_cnt6, 2'b01};
        else if (blue_win) result_d = {1'b1, win_cnt6, 2'b10};
        else               result_d = {1'b1, 6'd0, 2'b00};
        state_d = ACCUM;
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= WAIT_SYNC;
      red_cnt_q  <= '0;
      blue_cnt_q <= '0;
      snap_r_q   <= '0;
      snap_b_q   <= '0;
      result_q   <= '0;
      vs_d_q     <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      red_cnt_q  <= red_cnt_d;
      blue_cnt_q <= blue_cnt_d;
      snap_r_q   <= snap_r_d;
      snap_b_q   <= snap_b_d;
      result_q   <= result_d;
      vs_d_q     <= vs_d_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

endmodule

// File: tb/tb_frame_color_classifier.sv
// Scoreboarded bench for frame_color_classifier (MEM_LATENCY = 2).
// The driver issues one coordinate per cycle, delays the matching pixel by
// ML cycles, and runs a frame-level reference model that pushes the expected
// RESULT for every VSYNC fall and every reset cycle. An independent monitor
// watches the bus and pops/compares.
module tb_frame_color_classifier;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_color_classifier_if bus();

  frame_color_classifier #(.MEM_LATENCY(ML)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];

  // reference model state
  bit         armed    = 1'b0;
  int         mr       = 0;
  int         mb       = 0;
  bit         vs_prev  = 1'b1;
  logic [8:0] last_res = '0;
  logic [7:0] pix_dl [ML];
  bit         win_dl [ML];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: RESULT=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 none, 1 red, 2 blue -- straight from the colour rules
  function automatic int colour(input logic [7:0] p);
    int r, g, b;
    r = int'(p) / 32;
    g = (int'(p) / 4) % 8;
    b = int'(p) % 4;
    if (r >= 5 && g <= 1 && b <= 1) return 1;
    if (b >= 2 && r <= 2 && g <= 2) return 2;
    return 0;
  endfunction

  function automatic logic [8:0] decide(input int r, input int b);
    int c;
    if (r >= 2000 && r > b) begin
      c = r / 512; if (c > 63) c = 63;
      return {1'b1, 6'(c), 2'b01};
    end
    if (b >= 2000 && b > r) begin
      c = b / 512; if (c > 63) c = 63;
      return {1'b1, 6'(c), 2'b10};
    end
    return {1'b1, 6'd0, 2'b00};
  endfunction

  // One pixel-clock cycle: present coordinate (x,y), pixel for the coordinate
  // issued ML cycles ago, and vsync level; update the frame model.
  task automatic step(input int x, input int y, input logic [7:0] p, input logic vs);
    logic [7:0] ap;
    bit         aw;
    int         c;
    ap = pix_dl[ML-1];
    aw = win_dl[ML-1];
    for (int i = ML-1; i > 0; i--) begin
      pix_dl[i] = pix_dl[i-1];
      win_dl[i] = win_dl[i-1];
    end
    pix_dl[0] = p;
    win_dl[0] = (x < 176 && y < 144);
    bus.VGA_PIXEL_X   = 10'(x);
    bus.VGA_PIXEL_Y   = 10'(y);
    bus.PIXEL_IN      = ap;
    bus.VGA_VSYNC_NEG = vs;
    if (vs_prev && !vs) begin
      if (armed) last_res = decide(mr, mb);
      exp_q.push_back(last_res);
      armed = 1'b1;
      mr = 0;
      mb = 0;
    end else if (armed && aw) begin
      c = colour(ap);
      if (c == 1 && mr < 32767) mr++;
      if (c == 2 && mb < 32767) mb++;
    end
    vs_prev = vs;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      armed = 1'b0; mr = 0; mb = 0; last_res = '0; vs_prev = 1'b1;
      for (int i = 0; i < ML; i++) win_dl[i] = 1'b0;
      exp_q.push_back(9'd0);
      bus.VGA_PIXEL_X = 10'd1023; bus.VGA_PIXEL_Y = 10'd1023;
      bus.PIXEL_IN = 8'h00; bus.VGA_VSYNC_NEG = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic step_in(input logic [7:0] p);
    step($urandom_range(0, 175), $urandom_range(0, 143), p, 1'b1);
  endtask

  task automatic step_out(input logic [7:0] p, input logic vs);
    if ($urandom_range(0, 1) == 1) step($urandom_range(176, 639), $urandom_range(0, 479), p, vs);
    else                           step($urandom_range(0, 639), $urandom_range(144, 479), p, vs);
  endtask

  // Frame boundary: the red pixel landing on the fall cycle is dropped, the
  // following ML-1 reds land in DECIDE/ACCUM and start the next frame's count.
  task automatic pulse();
    step_in(8'h00);
    for (int i = 0; i < ML; i++) step_in(8'hE0);
    for (int i = 0; i < 4; i++) step_out(($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h03, 1'b0);
    for (int i = 0; i < 4; i++) step_out(8'h00, 1'b1);
  endtask

  task automatic full_frame(input logic [7:0] top, input logic [7:0] bot);
    for (int y = 0; y < 144; y++)
      for (int x = 0; x < 176; x++) step(x, y, (y < 72) ? top : bot, 1'b1);
  endtask

  // target red count in the frame: carry (ML-1) + baseline + the X=175 pixel
  task automatic thr_frame(input int target);
    int y;
    repeat (3) step_in(8'h00);
    repeat (target - ML) step_in(8'hE0);
    repeat (3) step_in(8'h00);
    y = $urandom_range(0, 143);
    step(174, y, 8'h00, 1'b1);
    step(175, y, 8'hE0, 1'b1);
    step(176, y, 8'hE0, 1'b1);
    step(177, y, 8'hE0, 1'b1);
    repeat (3) step(200, y, 8'h00, 1'b1);
  endtask

  // monitor
  initial begin
    logic [8:0] cur;
    bit         vp, rst_prev;
    int         fall_cd;
    cur = '0; vp = 1'b1; rst_prev = 1'b0; fall_cd = 0;
    forever begin
      @(negedge clk);
      if (rst_prev || fall_cd == 1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL underflow: RESULT=%b with nothing expected at %0t", bus.RESULT, $time);
        end else begin
          cur = exp_q.pop_front();
          chk(rst_prev ? "reset" : "frame_result", bus.RESULT, cur);
        end
      end
      if (fall_cd > 0) fall_cd--;
      if (!rst && vp && !bus.VGA_VSYNC_NEG) begin
        chk("held_until_fall", bus.RESULT, cur);
        fall_cd = 3;
      end
      vp = bus.VGA_VSYNC_NEG;
      rst_prev = rst;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nr, nb;
    for (int i = 0; i < ML; i++) begin pix_dl[i] = 8'h00; win_dl[i] = 1'b0; end
    bus.VGA_PIXEL_X = 10'd1023; bus.VGA_PIXEL_Y = 10'd1023;
    bus.PIXEL_IN = 8'h00; bus.VGA_VSYNC_NEG = 1'b1;
    @(posedge clk); #1;
    do_reset(3);

    repeat (100) step_in(8'hE0);   // before first sync: ignored
    pulse();                       // RESULT stays 0
    full_frame(8'hE0, 8'hE0);      // red
    pulse();
    full_frame(8'h03, 8'h03);      // blue
    pulse();
    repeat (600) step_out(8'hE0, 1'b1);   // red outside window only
    pulse();
    nr = 2600 - (ML - 1); nb = 2600;      // tie after the carried red
    while (nr + nb > 0) begin
      if ($urandom_range(0, nr + nb - 1) < nr) begin step_in(8'hE0); nr--; end
      else begin step_in(8'h03); nb--; end
    end
    pulse();
    thr_frame(1999);
    pulse();
    thr_frame(2000);
    pulse();
    repeat (6000) begin
      if ($urandom_range(0, 4) != 0) step_in(8'($urandom));
      else step_out(8'($urandom), 1'b1);
    end
    pulse();
    for (int i = 0; i < 300; i++) step($urandom_range(0, 175), $urandom_range(0, 69), 8'hE0, 1'b1);
    do_reset(1);                   // mid-frame reset at row 70
    for (int i = 0; i < 200; i++) step($urandom_range(0, 175), $urandom_range(70, 143), 8'hE0, 1'b1);
    pulse();                       // no update after reset
    repeat (2600) step_in(8'hE0);
    pulse();                       // red again
    repeat (10) step_out(8'h00, 1'b1);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected results never observed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
